// File: rtl/synapse_accumulator_if.sv
// synapse_accumulator_if: tick/spike, weight-write and result signals between the input layer and synapse_accumulator.
interface synapse_accumulator_if #(
    parameter int N_INPUTS = 8,
    parameter int W_WIDTH  = 16
);
    localparam int IDX_W = $clog2(N_INPUTS);
    logic                tick;
    logic [N_INPUTS-1:0] pre_spike;
    logic                wr_en;
    logic [IDX_W-1:0]    wr_addr;
    logic [W_WIDTH-1:0]  wr_data;
    logic                busy;
    logic [W_WIDTH-1:0]  spiking_value;
    logic                value_valid;
    modport master (
        output tick, pre_spike, wr_en, wr_addr, wr_data,
        input  busy, spiking_value, value_valid
    );
    modport slave (
        input  tick, pre_spike, wr_en, wr_addr, wr_data,
        output busy, spiking_value, value_valid
    );
endinterface

// File: rtl/synapse_accumulator.sv
// synapse_accumulator: serial spike-weighted sum over N_INPUTS synapses per tick.
// Define SYN_SAT_EN to saturate the result to W_WIDTH bits; otherwise it wraps.
module synapse_accumulator #(
    parameter int N_INPUTS = 8,
    parameter int W_WIDTH  = 16
) (
    input logic clk,
    input logic rst,
    synapse_accumulator_if.slave bus
);
    localparam int IDX_W = $clog2(N_INPUTS);
    localparam int ACC_W = W_WIDTH + IDX_W + 1;
    typedef enum logic {IDLE, ACCUM} state_t;
    state_t                    state_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic [IDX_W-1:0]          idx_q;
    logic [N_INPUTS-1:0]       spk_q;
    logic [W_WIDTH-1:0]        val_q;
    logic                      vld_q;
    logic signed [W_WIDTH-1:0] w_q [N_INPUTS];
    logic signed [ACC_W-1:0]   term;
    logic signed [ACC_W-1:0]   sum;
    logic [W_WIDTH-1:0]        val_d;
    logic                      last;
    always_comb begin
        term = spk_q[idx_q] ? ACC_W'(w_q[idx_q]) : '0;
        sum  = acc_q + term;
        last = idx_q == IDX_W'(N_INPUTS - 1);
    end
`ifdef SYN_SAT_EN
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((2 ** (W_WIDTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] MINV = -MAXV - 1;
    always_comb val_d = sum > MAXV ? MAXV[W_WIDTH-1:0] : sum < MINV ? MINV[W_WIDTH-1:0] : sum[W_WIDTH-1:0];
`else
    always_comb val_d = sum[W_WIDTH-1:0];
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            idx_q   <= '0;
            spk_q   <= '0;
            val_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            vld_q <= 1'b0;
            if (state_q == IDLE) begin
                if (bus.tick) begin
                    spk_q   <= bus.pre_spike;
                    acc_q   <= '0;
                    idx_q   <= '0;
                    state_q <= ACCUM;
                end
            end else if (last) begin
                val_q   <= val_d;
                vld_q   <= 1'b1;
                state_q <= IDLE;
            end else begin
                acc_q <= sum;
                idx_q <= idx_q + 1'b1;
            end
        end
    end
    // Out-of-range addresses match no decoder and are dropped.
    for (genvar i = 0; i < N_INPUTS; i++) begin : g_w
        always_ff @(posedge clk or posedge rst) begin
            if (rst) w_q[i] <= '0;
            else if (bus.wr_en && bus.wr_addr == IDX_W'(i)) w_q[i] <= bus.wr_data;
        end
    end
    assign bus.busy          = state_q != IDLE;
    assign bus.spiking_value = val_q;
    assign bus.value_valid   = vld_q;
endmodule

// File: tb/tb_synapse_accumulator.sv
// tb_synapse_accumulator: directed and random timesteps checked against a weighted-sum reference model.
module tb_synapse_accumulator;
    localparam int N = 8;
    localparam int W = 16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;
    int m_w [N];
    synapse_accumulator_if #(.N_INPUTS(N), .W_WIDTH(W)) bus ();
    synapse_accumulator #(.N_INPUTS(N), .W_WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic logic [W-1:0] model(input logic [N-1:0] spk);
        longint s = 0;
        for (int i = 0; i < N; i++) if (spk[i]) s += m_w[i];
`ifdef SYN_SAT_EN
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`endif
        return W'(s);
    endfunction
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic wr(input int a, input logic [W-1:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'(a);
        bus.wr_data = d;
        step();
        bus.wr_en = 1'b0;
        m_w[a] = int'($signed(d));
    endtask
    // disturb: extra tick and pre_spike cleared at cycle 3, w0 rewritten at cycle 4
    task automatic run(input string tag, input logic [N-1:0] spk, input bit disturb);
        logic [W-1:0] exp;
        exp = model(spk);
        bus.tick      = 1'b1;
        bus.pre_spike = spk;
        step();
        bus.tick = 1'b0;
        for (int c = 1; c <= N; c++) begin
            if (disturb && c == 3) begin
                bus.tick      = 1'b1;
                bus.pre_spike = '0;
            end
            if (disturb && c == 4) begin
                bus.tick    = 1'b0;
                bus.wr_en   = 1'b1;
                bus.wr_addr = '0;
                bus.wr_data = '0;
            end
            if (disturb && c == 5) bus.wr_en = 1'b0;
            chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
            chk({tag, "_vld_early"}, 32'(bus.value_valid), 32'd0);
            step();
        end
        if (disturb) m_w[0] = 0;
        chk({tag, "_vld"}, 32'(bus.value_valid), 32'd1);
        chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
        chk({tag, "_val"}, 32'(bus.spiking_value), 32'(exp));
        step();
        chk({tag, "_vld_once"}, 32'(bus.value_valid), 32'd0);
        chk({tag, "_hold"}, 32'(bus.spiking_value), 32'(exp));
    endtask
    initial begin
        bus.tick = 1'b0;
        bus.pre_spike = '0;
        bus.wr_en = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        for (int i = 0; i < N; i++) m_w[i] = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_vld", 32'(bus.value_valid), 32'd0);
        chk("rst_val", 32'(bus.spiking_value), 32'd0);
        run("zero_w", 8'hFF, 1'b0);
        for (int i = 0; i < N; i++) wr(i, W'(100 * (i + 1)));
        run("a5", 8'b1010_0101, 1'b0);
        chk("a5_const", 32'(bus.spiking_value), 32'h0708);
        for (int i = 0; i < N; i++) wr(i, '0);
        wr(0, -16'sd500);
        wr(1, 16'sd200);
        run("neg", 8'h03, 1'b0);
        chk("neg_const", 32'(bus.spiking_value), 32'hFED4);
        for (int i = 0; i < N; i++) wr(i, 16'h7000);
        run("big", 8'hFF, 1'b0);
`ifdef SYN_SAT_EN
        chk("big_const", 32'(bus.spiking_value), 32'h7FFF);
`else
        chk("big_const", 32'(bus.spiking_value), 32'h8000);
`endif
        for (int i = 0; i < N; i++) wr(i, W'(100 * (i + 1)));
        run("flight", 8'b1010_0101, 1'b1);
        chk("flight_const", 32'(bus.spiking_value), 32'd1800);
        run("next", 8'b1010_0101, 1'b0);
        chk("next_const", 32'(bus.spiking_value), 32'd1700);
        bus.tick = 1'b1;
        bus.pre_spike = 8'hFF;
        step();
        bus.tick = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_val", 32'(bus.spiking_value), 32'd0);
        chk("mid_rst_vld", 32'(bus.value_valid), 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < N; i++) m_w[i] = 0;
        for (int c = 0; c < N + 2; c++) begin
            chk("post_rst_novld", 32'(bus.value_valid), 32'd0);
            step();
        end
        run("post_rst", 8'hFF, 1'b0);
        for (int t = 0; t < 25; t++) begin
            for (int k = 0; k < 3; k++) wr(int'($urandom_range(N - 1)), W'($urandom));
            run("rand", N'($urandom), 1'b0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
